// File: rtl/stream_mux_pkg.sv
// Shared constants, types and helpers for the stream_mux_rr block.
// The optional per-channel lock is built when STREAM_MUX_LAST_LOCK_EN is defined.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Widest request vector the index helper accepts; callers zero-extend into it.
  localparam int IDX_MAX_N = 64;
  localparam int IDX_MAX_W = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Lowest set bit wins, so a non-one-hot vector still yields a legal index.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [IDX_MAX_N-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = IDX_MAX_N - 1; i >= 0; i--) begin
      if (oh[i]) begin
        idx = IDX_MAX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
// Purely combinational; the owner of ptr decides when it advances.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_idx;
  logic          w_found;

  // Scan ptr+1 .. ptr+N so the channel at ptr has the lowest priority.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_idx = SW'((int'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign grant       = w_grant;
  assign grant_valid = w_found;
  assign grant_idx   = SW'(onehot_to_idx(IDX_MAX_N'(w_grant)));

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with registered output, explicit-select or round-robin mode.
// Define STREAM_MUX_LAST_LOCK_EN to add in_last and hold the grant across a packet.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic [N-1:0]  in_valid,
  input  logic [N*W-1:0] in_data,
`ifdef STREAM_MUX_LAST_LOCK_EN
  input  logic [N-1:0]  in_last,
`endif
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_sel,
  input  logic          out_ready
);

  out_state_e    r_state;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic [SW-1:0] r_rr_ptr;

  logic [N-1:0]  w_arb_grant;
  logic [SW-1:0] w_arb_idx;
  logic          w_arb_valid;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_grant_idx;
  logic          w_grant_valid;
  logic          w_accept;
  logic          w_load;
  logic          w_lock_active;
  logic [SW-1:0] w_lock_idx;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (r_rr_ptr),
    .grant       (w_arb_grant),
    .grant_idx   (w_arb_idx),
    .grant_valid (w_arb_valid)
  );

  // A held lock overrides both modes; an out-of-range sel grants nothing.
  always_comb begin
    w_grant = '0;
    if (w_lock_active) begin
      if (in_valid[w_lock_idx]) begin
        w_grant[w_lock_idx] = 1'b1;
      end else begin
        w_grant = '0;
      end
    end else if (mode == MODE_SEL) begin
      if ((int'(sel) < N) && in_valid[sel]) begin
        w_grant[sel] = 1'b1;
      end else begin
        w_grant = '0;
      end
    end else begin
      w_grant = w_arb_grant;
    end
  end

  assign w_grant_valid = |w_grant;
  assign w_grant_idx   = SW'(onehot_to_idx(IDX_MAX_N'(w_grant)));
  assign w_accept      = (r_state == ST_EMPTY) || out_ready;
  assign w_load        = w_accept && w_grant_valid;
  assign in_ready      = (rst_n && w_accept) ? w_grant : '0;

  // Output stage FSM with the data register and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_out_data <= '0;
      r_out_sel  <= '0;
      r_rr_ptr   <= SW'(N - 1);
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) r_state <= ST_FULL;
          else        r_state <= ST_EMPTY;
        end
        ST_FULL: begin
          if (out_ready && !w_load) r_state <= ST_EMPTY;
          else                      r_state <= ST_FULL;
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_load) begin
        r_out_data <= in_data[int'(w_grant_idx)*W +: W];
        r_out_sel  <= w_grant_idx;
      end else begin
        r_out_data <= r_out_data;
        r_out_sel  <= r_out_sel;
      end
      // The pointer only tracks round-robin grants; explicit selects leave it alone.
      if (w_load && (mode == MODE_RR)) begin
        r_rr_ptr <= w_grant_idx;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic          r_locked;
  logic [SW-1:0] r_lock_idx;

  // Every loaded beat either opens or closes the lock on its own channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_load) begin
      r_locked   <= !in_last[w_grant_idx];
      r_lock_idx <= w_grant_idx;
    end else begin
      r_locked   <= r_locked;
      r_lock_idx <= r_lock_idx;
    end
  end

  assign w_lock_active = r_locked;
  assign w_lock_idx    = r_lock_idx;
`else
  assign w_lock_active = 1'b0;
  assign w_lock_idx    = '0;
`endif

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios, then randomized traffic
// against a behavioural model. Lock scenarios build when STREAM_MUX_LAST_LOCK_EN is defined.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic [N-1:0]   in_last;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_ov;
  logic [W-1:0] m_data;
  int          m_sel;
  int          m_ptr;
  bit          m_locked;
  int          m_lock_idx;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_MUX_LAST_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov       = 1'b0;
    m_data     = '0;
    m_sel      = 0;
    m_ptr      = N - 1;
    m_locked   = 1'b0;
    m_lock_idx = 0;
  endtask

  // Which channel the rules say should be granted now, or -1 for none.
  function automatic int model_pick();
    if (m_locked) return in_valid[m_lock_idx] ? m_lock_idx : -1;
    if (mode == 1'b0) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_default_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'hA0 + 32'(k);
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = model_pick();
    exp_rdy = '0;
    if (rst_n && g >= 0 && (!m_ov || out_ready)) exp_rdy = N'(1) << g;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != '0) begin
      m_ov   = 1'b1;
      m_data = in_data[g*W +: W];
      m_sel  = g;
      if (mode == 1'b1) m_ptr = g;
`ifdef STREAM_MUX_LAST_LOCK_EN
      if (in_last[g]) m_locked = 1'b0;
      else begin
        m_locked   = 1'b1;
        m_lock_idx = g;
      end
`endif
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_sel", 64'(out_sel), 64'(m_sel));
    check("out_data", 64'(out_data), 64'(m_data));
  endtask

  // Called just after a posedge; releases reset shortly before the next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_sel", 64'(out_sel), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 64'(out_valid), 64'h0);
    check("rst_hold_ready", 64'(in_ready), 64'h0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0]  held_data;
    logic [SW-1:0] held_sel;
    int            seq5 [4];
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
`ifdef STREAM_MUX_LAST_LOCK_EN
    in_last   = 4'b1111;
`endif
    set_default_data();
    model_reset();
    @(posedge clk);
    #1;

    // 1: reset with every channel valid, then first load right after release
    do_reset();
    step();
    check("t1_first_sel", 64'(out_sel), 64'h0);
    check("t1_first_data", 64'(out_data), 64'hA0);

    // 2: explicit select of channel 2
    mode = 1'b0;
    sel  = 2'd2;
    #1;
    check("t2_in_ready", 64'(in_ready), 64'h4);
    step();
    check("t2_data", 64'(out_data), 64'hA2);
    check("t2_sel", 64'(out_sel), 64'h2);

    // 3: round-robin across all four channels at full throughput
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_rr_sel", 64'(out_sel), 64'(k % N));
      check("t3_rr_valid", 64'(out_valid), 64'h1);
    end

    // 4: downstream backpressure holds the beat, then resume at the next channel
    out_ready = 1'b0;
    held_data = out_data;
    held_sel  = out_sel;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_hold_data", 64'(out_data), 64'(held_data));
      check("t4_hold_sel", 64'(out_sel), 64'(held_sel));
      check("t4_hold_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1;
    step();
    check("t4_resume_sel", 64'(out_sel), 64'((int'(held_sel) + 1) % N));

    // 5: sparse requesters, then a reset pulse mid-run
    do_reset();
    in_valid = 4'b1010;
    seq5 = '{1, 3, 1, 3};
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_sparse_sel", 64'(out_sel), 64'(seq5[k]));
    end
    do_reset();
    step();
    check("t5_post_rst_sel", 64'(out_sel), 64'h1);

`ifdef STREAM_MUX_LAST_LOCK_EN
    // 6: channel 0 holds the grant until its last beat
    do_reset();
    in_valid = 4'b0011;
    in_last  = 4'b0000;
    step();
    check("t6_sel0", 64'(out_sel), 64'h0);
    step();
    check("t6_sel1", 64'(out_sel), 64'h0);
    in_last = 4'b0001;
    step();
    check("t6_sel2", 64'(out_sel), 64'h0);
    in_last = 4'b1111;
    step();
    check("t6_sel3", 64'(out_sel), 64'h1);
`endif

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
`ifdef STREAM_MUX_LAST_LOCK_EN
      in_last   = N'($urandom) | N'($urandom);
`endif
      if ($urandom_range(0, 49) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
